// File: rtl/nrzi_decode_par_pkg.sv
// ============================================================================
// Module : nrzi_decode_par_pkg
// Brief  : Shared types for the parallel NRZI decoder (line-lock state).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nrzi_decode_par_pkg;

    // Line-lock state: PRIME waits for a reference bit, RUN holds one.
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } lock_state_e;

endpackage : nrzi_decode_par_pkg

`default_nettype wire

// File: rtl/nrzi_runlen_check.sv
// ============================================================================
// Module : nrzi_runlen_check
// Brief  : Zero-run checker on the decoded NRZ stream. Walks the valid bits
//          of each word oldest-first, carries the run count across words and
//          pulses run_err_o for every word holding a zero beyond MAX_ZEROS.
//          Instantiated by nrzi_decode_par only with NRZI_RUNLEN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nrzi_runlen_check #(
    parameter int WIDTH     = 2,
    parameter int MAX_ZEROS = 3,
    localparam int CW       = $clog2(WIDTH + 1),
    localparam int ZW       = $clog2(MAX_ZEROS + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] nrz_i,
    input  logic [CW-1:0]    nrz_valid_i,
    output logic             run_err_o
);

    localparam logic [ZW-1:0] C_MAXZ = ZW'(MAX_ZEROS);

    logic [ZW-1:0] zcnt_q;
    logic [ZW-1:0] zcnt_d;
    logic          run_err_q;
    logic          run_err_d;

    // Walk the word oldest-first; the count saturates one past the legal limit.
    always_comb begin
        zcnt_d    = clear_i ? '0 : zcnt_q;
        run_err_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) < nrz_valid_i) begin
                if (nrz_i[WIDTH-1-i]) begin
                    zcnt_d = '0;
                end else begin
                    if (zcnt_d <= C_MAXZ) begin
                        zcnt_d = zcnt_d + 1'b1;
                    end
                    if (zcnt_d > C_MAXZ) begin
                        run_err_d = 1'b1;
                    end
                end
            end
        end
    end

    // Register the count and the violation pulse alongside the decoded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zcnt_q    <= '0;
            run_err_q <= 1'b0;
        end else begin
            zcnt_q    <= zcnt_d;
            run_err_q <= run_err_d;
        end
    end

    assign run_err_o = run_err_q;

endmodule : nrzi_runlen_check

`default_nettype wire

// File: rtl/nrzi_decode_par.sv
// ============================================================================
// Module : nrzi_decode_par
// Brief  : Parallel NRZI-to-NRZ decoder for the 100BASE-X receive path.
//          Up to WIDTH line bits per cycle (MSB-aligned, oldest at MSB), one
//          decoded bit per line bit after the first reference bit. All
//          outputs registered, one cycle latency.
//          Optional zero-run checker: define NRZI_RUNLEN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nrzi_decode_par
    import nrzi_decode_par_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int MAX_ZEROS = 3,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             resync_i,
    input  logic [WIDTH-1:0] nrzi_i,
    input  logic [CW-1:0]    nrzi_valid_i,
    output logic [WIDTH-1:0] nrz_o,
    output logic [CW-1:0]    nrz_valid_o,
    output logic             locked_o,
    output logic             run_err_o
);

    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

    lock_state_e      state_q;
    logic             last_q;
    logic [WIDTH-1:0] nrz_q;
    logic [CW-1:0]    nrz_valid_q;

    logic [CW-1:0]    k;
    logic             prime;
    logic [WIDTH-1:0] xor_bits;
    logic [WIDTH-1:0] run_bits;
    logic [WIDTH-1:0] prime_bits;
    logic [WIDTH-1:0] nrz_d;
    logic [CW-1:0]    nrz_valid_d;
    logic             last_d;

    // Clamp the bit count; over-range counts are treated as a full word.
    always_comb begin
        k = (nrzi_valid_i > C_WIDTH) ? C_WIDTH : nrzi_valid_i;
    end

    // A resync forces this cycle's word to be treated as the priming word.
    assign prime = resync_i | (state_q == PRIME);

    // Per-position transition detect. In RUN a bit is valid if it lies within
    // the first k; in PRIME the oldest bit is consumed as reference, so the
    // decoded word is the RUN word shifted up by one position.
    for (genvar p = 0; p < WIDTH; p++) begin : g_bit
        if (p == WIDTH - 1) begin : g_msb
            assign xor_bits[p] = nrzi_i[p] ^ last_q;
        end else begin : g_inner
            assign xor_bits[p] = nrzi_i[p] ^ nrzi_i[p+1];
        end

        assign run_bits[p] = xor_bits[p] & (CW'(WIDTH - 1 - p) < k);

        if (p == 0) begin : g_lsb
            assign prime_bits[p] = 1'b0;
        end else begin : g_upper
            assign prime_bits[p] = xor_bits[p-1] & (CW'(WIDTH - p) < k);
        end
    end

    // Select the decoded word and its count for this cycle.
    always_comb begin
        nrz_d       = prime ? prime_bits : run_bits;
        nrz_valid_d = '0;
        if (k != '0) begin
            nrz_valid_d = prime ? (k - 1'b1) : k;
        end
    end

    // New line reference: the youngest valid line bit, nrzi_i[WIDTH-k].
    always_comb begin
        last_d = last_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (k == CW'(WIDTH - i)) begin
                last_d = nrzi_i[i];
            end
        end
    end

    // Lock FSM plus registered decoder outputs; empty words leave state alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRIME;
            last_q      <= 1'b0;
            nrz_q       <= '0;
            nrz_valid_q <= '0;
        end else begin
            nrz_q       <= nrz_d;
            nrz_valid_q <= nrz_valid_d;
            if (k != '0) begin
                last_q  <= last_d;
                state_q <= RUN;
            end else if (resync_i) begin
                state_q <= PRIME;
            end
        end
    end

    assign nrz_o       = nrz_q;
    assign nrz_valid_o = nrz_valid_q;
    assign locked_o    = (state_q == RUN);

`ifdef NRZI_RUNLEN_CHECK_EN
    nrzi_runlen_check #(
        .WIDTH     (WIDTH),
        .MAX_ZEROS (MAX_ZEROS)
    ) u_runlen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (prime),
        .nrz_i       (nrz_d),
        .nrz_valid_i (nrz_valid_d),
        .run_err_o   (run_err_o)
    );
`else
    assign run_err_o = 1'b0;
`endif

endmodule : nrzi_decode_par

`default_nettype wire

// File: tb/tb_nrzi_decode_par.sv
// ============================================================================
// Module : tb_nrzi_decode_par
// Brief  : Directed checks on a WIDTH=2 decoder and a randomised comparison of
//          a WIDTH=5 decoder against a bit-serial reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nrzi_decode_par;

`ifdef NRZI_RUNLEN_CHECK_EN
    localparam bit RL_EN = 1'b1;
`else
    localparam bit RL_EN = 1'b0;
`endif
    localparam int MZ = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=2 instance
    logic       rs2 = 1'b0;
    logic [1:0] d2  = '0;
    logic [1:0] v2  = '0;
    logic [1:0] nrz2;
    logic [1:0] nv2;
    logic       lk2;
    logic       er2;

    // WIDTH=5 instance
    logic       rs5 = 1'b0;
    logic [4:0] d5  = '0;
    logic [2:0] v5  = '0;
    logic [4:0] nrz5;
    logic [2:0] nv5;
    logic       lk5;
    logic       er5;

    int checks   = 0;
    int failures = 0;

    nrzi_decode_par #(.WIDTH(2), .MAX_ZEROS(MZ)) dut2 (
        .clk(clk), .rst_n(rst_n), .resync_i(rs2), .nrzi_i(d2), .nrzi_valid_i(v2),
        .nrz_o(nrz2), .nrz_valid_o(nv2), .locked_o(lk2), .run_err_o(er2)
    );

    nrzi_decode_par #(.WIDTH(5), .MAX_ZEROS(MZ)) dut5 (
        .clk(clk), .rst_n(rst_n), .resync_i(rs5), .nrzi_i(d5), .nrzi_valid_i(v5),
        .nrz_o(nrz5), .nrz_valid_o(nv5), .locked_o(lk5), .run_err_o(er5)
    );

    // Apply one word to the WIDTH=2 instance and sample just after the edge.
    task automatic step2(input logic [1:0] d, input logic [1:0] v, input logic rs);
        d2 = d; v2 = v; rs2 = rs;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d2 = 2'($urandom); v2 = 2'($urandom); rs2 = 1'($urandom);
            d5 = 5'($urandom); v5 = 3'($urandom);
            @(negedge clk);
        end
        checks++; if (nrz2 !== 2'b00) begin failures++; $display("FAIL reset_nrz actual=%b required=00", nrz2); end
        checks++; if (nv2 !== 2'd0) begin failures++; $display("FAIL reset_nrz_valid actual=%0d required=0", nv2); end
        checks++; if (lk2 !== 1'b0) begin failures++; $display("FAIL reset_locked actual=%b required=0", lk2); end
        checks++; if (er2 !== 1'b0) begin failures++; $display("FAIL reset_run_err actual=%b required=0", er2); end
        checks++; if (lk5 !== 1'b0 || nv5 !== 3'd0) begin failures++; $display("FAIL reset_w5 locked=%b valid=%0d required 0/0", lk5, nv5); end
        d2 = '0; v2 = '0; rs2 = 1'b0; d5 = '0; v5 = '0; rs5 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (nrz2 !== 2'b00 || nv2 !== 2'd0 || lk2 !== 1'b0 || er2 !== 1'b0) begin
            failures++; $display("FAIL reset_release nrz=%b valid=%0d locked=%b err=%b required all 0", nrz2, nv2, lk2, er2);
        end
    endtask

    task automatic test_prime();
        step2(2'b10, 2'd1, 1'b0);
        checks++; if (nv2 !== 2'd0 || nrz2 !== 2'b00) begin failures++; $display("FAIL prime_word valid=%0d nrz=%b required 0/00", nv2, nrz2); end
        checks++; if (lk2 !== 1'b1) begin failures++; $display("FAIL prime_locked actual=%b required=1", lk2); end
        step2(2'b01, 2'd2, 1'b0);
        checks++; if (nrz2 !== 2'b11 || nv2 !== 2'd2) begin failures++; $display("FAIL prime_first_run nrz=%b valid=%0d required 11/2", nrz2, nv2); end
    endtask

    // Entered with locked=1, last=1.
    task automatic test_partial();
        step2(2'b10, 2'd1, 1'b0);
        checks++; if (nrz2 !== 2'b00 || nv2 !== 2'd1) begin failures++; $display("FAIL partial_k1 nrz=%b valid=%0d required 00/1", nrz2, nv2); end
        step2(2'b11, 2'd0, 1'b0);
        checks++; if (nrz2 !== 2'b00 || nv2 !== 2'd0 || lk2 !== 1'b1) begin failures++; $display("FAIL partial_k0 nrz=%b valid=%0d locked=%b required 00/0/1", nrz2, nv2, lk2); end
        // last must still be 1: 2'b01 decodes to 11
        step2(2'b01, 2'd2, 1'b0);
        checks++; if (nrz2 !== 2'b11 || nv2 !== 2'd2) begin failures++; $display("FAIL partial_last_held nrz=%b valid=%0d required 11/2", nrz2, nv2); end
    endtask

    // Entered with locked=1, last=1.
    task automatic test_resync();
        step2(2'b11, 2'd2, 1'b1);
        checks++; if (nrz2 !== 2'b00 || nv2 !== 2'd1 || lk2 !== 1'b1) begin failures++; $display("FAIL resync_k2 nrz=%b valid=%0d locked=%b required 00/1/1", nrz2, nv2, lk2); end
        step2(2'b00, 2'd0, 1'b1);
        checks++; if (lk2 !== 1'b0 || nv2 !== 2'd0) begin failures++; $display("FAIL resync_k0 locked=%b valid=%0d required 0/0", lk2, nv2); end
        step2(2'b01, 2'd2, 1'b0);
        checks++; if (nrz2 !== 2'b10 || nv2 !== 2'd1 || lk2 !== 1'b1) begin failures++; $display("FAIL reprime nrz=%b valid=%0d locked=%b required 10/1/1", nrz2, nv2, lk2); end
    endtask

    // Entered with locked=1, last=1.
    task automatic test_runlen();
        logic [3:0] exp_err;
        exp_err = RL_EN ? 4'b0110 : 4'b0000;
        step2(2'b11, 2'd2, 1'b1);
        checks++; if (er2 !== 1'b0) begin failures++; $display("FAIL runlen_prime actual=%b required=0", er2); end
        for (int w = 0; w < 3; w++) begin
            step2(2'b11, 2'd2, 1'b0);
            checks++; if (er2 !== exp_err[w] || nrz2 !== 2'b00) begin
                failures++; $display("FAIL runlen_word%0d err=%b nrz=%b required %b/00", w, er2, nrz2, exp_err[w]);
            end
        end
        step2(2'b01, 2'd2, 1'b0);
        checks++; if (er2 !== 1'b0 || nrz2 !== 2'b11) begin failures++; $display("FAIL runlen_clear err=%b nrz=%b required 0/11", er2, nrz2); end
    endtask

    // Entered with locked=1, last=1. Count 3 is clamped to 2.
    task automatic test_clamp();
        step2(2'b10, 2'd3, 1'b0);
        checks++; if (nrz2 !== 2'b01 || nv2 !== 2'd2) begin failures++; $display("FAIL clamp nrz=%b valid=%0d required 01/2", nrz2, nv2); end
        step2(2'b00, 2'd0, 1'b0);
    endtask

    // WIDTH=5 random stimulus against a bit-serial model.
    task automatic test_random_w5();
        bit       mlocked = 1'b0;
        bit       mlast   = 1'b0;
        int       mcnt    = 0;
        int       kk, n, cnt;
        bit       pr, rf, b, e, err;
        logic [4:0] eout;
        logic [2:0] ev;
        int       shown = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            d5  = 5'($urandom);
            v5  = 3'($urandom_range(0, 7));
            rs5 = ($urandom_range(0, 15) == 0);
            kk  = (int'(v5) > 5) ? 5 : int'(v5);
            pr  = rs5 || !mlocked;
            cnt = pr ? 0 : mcnt;
            rf  = mlast; n = 0; eout = '0; err = 1'b0;
            for (int i = 0; i < kk; i++) begin
                b = d5[4-i];
                if (i == 0 && pr) begin
                    rf = b;
                end else begin
                    e = b ^ rf;
                    eout[4-n] = e;
                    n++;
                    if (e) cnt = 0;
                    else begin
                        if (cnt <= MZ) cnt++;
                        if (cnt > MZ) err = 1'b1;
                    end
                    rf = b;
                end
            end
            if (kk > 0) begin mlast = rf; mlocked = 1'b1; end
            else if (rs5) mlocked = 1'b0;
            mcnt = cnt;
            ev = 3'(n);
            @(posedge clk); #1;
            checks++;
            if (nrz5 !== eout || nv5 !== ev || lk5 !== mlocked || er5 !== (err & RL_EN)) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL w5_cycle%0d nrz=%b valid=%0d locked=%b err=%b required %b/%0d/%b/%b",
                             cyc, nrz5, nv5, lk5, er5, eout, ev, mlocked, err & RL_EN);
                end
            end
        end
        d5 = '0; v5 = '0; rs5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prime();
        test_partial();
        test_resync();
        test_runlen();
        test_clamp();
        test_random_w5();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nrzi_decode_par

`default_nettype wire
